// File: rtl/dram_arb_pkg.sv
// Shared types for the two-master DRAM bus arbiter: state encoding,
// default fairness limit and the bundled 68k-style bus fields.
package dram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_CPU_ACCESS  = 3'd1,
    ST_CPU_RELEASE = 3'd2,
    ST_DMA_ACCESS  = 3'd3,
    ST_DMA_RELEASE = 3'd4
  } arb_state_e;

  localparam int DEF_DMA_STARVE_LIMIT = 4;

  typedef struct packed {
    logic [31:0] address;
    logic [15:0] data_in;
    logic        uds_l;
    logic        lds_l;
    logic        we_l;
    logic        as_l;
    logic        dram_select_l;
  } dram_bus_t;

  // Bus with every strobe negated; address/data come from the held copy so
  // the controller inputs do not toggle between owners.
  function automatic dram_bus_t parked_bus(input logic [31:0] addr,
                                           input logic [15:0] data);
    dram_bus_t b;
    b.address       = addr;
    b.data_in       = data;
    b.uds_l         = 1'b1;
    b.lds_l         = 1'b1;
    b.we_l          = 1'b1;
    b.as_l          = 1'b1;
    b.dram_select_l = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/dram_arb_starve_counter.sv
// Saturating count of CPU wins taken while the DMA was also waiting.
module dram_arb_starve_counter
  import dram_arb_pkg::*;
#(
  parameter int LIMIT = DEF_DMA_STARVE_LIMIT,
  parameter int CNT_W = 3
) (
  input  logic Clock,
  input  logic Reset_L,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; the count parks at LIMIT instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge Clock) begin
    if (!Reset_L) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/dram_bus_arbiter.sv
// Two-master (68k CPU / word DMA) arbiter in front of the SDRAM controller.
//
// state          | meaning
// ---------------+-----------------------------------------------------
// ST_IDLE        | no owner, strobes high, arbitrate on this edge
// ST_CPU_ACCESS  | CPU drives the controller, Dtack passed back to CPU
// ST_CPU_RELEASE | one forced AS_L-high cycle after CPU ownership
// ST_DMA_ACCESS  | DMA word access in flight, waiting for Dram_Dtack_L
// ST_DMA_RELEASE | Dma_Ack_H pulse, AS_L high before the next owner
module dram_bus_arbiter
  import dram_arb_pkg::*;
#(
  parameter int DMA_STARVE_LIMIT = DEF_DMA_STARVE_LIMIT,
  parameter int CNT_W            = 3
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic [31:0] Cpu_Address,
  input  logic [15:0] Cpu_DataIn,
  input  logic        Cpu_UDS_L,
  input  logic        Cpu_LDS_L,
  input  logic        Cpu_WE_L,
  input  logic        Cpu_AS_L,
  input  logic        Cpu_DramSelect_L,
  output logic        Cpu_Dtack_L,
  input  logic        Dma_Req_H,
  input  logic [31:0] Dma_Address,
  input  logic [15:0] Dma_DataIn,
  input  logic        Dma_WE_L,
  output logic        Dma_Ack_H,
  output logic [15:0] Dma_DataOut,
  output logic [31:0] Dram_Address,
  output logic [15:0] Dram_DataIn,
  output logic        Dram_UDS_L,
  output logic        Dram_LDS_L,
  output logic        Dram_WE_L,
  output logic        Dram_AS_L,
  output logic        Dram_DramSelect_L,
  input  logic [15:0] Dram_DataOut,
  input  logic        Dram_Dtack_L,
  output logic [2:0]  ArbState
);

  arb_state_e  state_q, state_d;
  logic [31:0] hold_addr_q;
  logic [15:0] hold_data_q;
  logic [15:0] dma_data_q;
  logic        ack_q;

  logic        cpu_req, dma_req;
  logic        cnt_inc, cnt_clr, at_limit;
  logic        dma_done;
  dram_bus_t   cpu_bus, dma_bus, bus;

  // An AS_L cycle outside the DRAM window is some other device's access.
  assign cpu_req  = !Cpu_AS_L && !Cpu_DramSelect_L;
  assign dma_req  = Dma_Req_H;
  assign dma_done = (state_q == ST_DMA_ACCESS) && !Dram_Dtack_L;

  dram_arb_starve_counter #(
    .LIMIT (DMA_STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve (
    .Clock      (Clock),
    .Reset_L    (Reset_L),
    .inc_i      (cnt_inc),
    .clr_i      (cnt_clr),
    .at_limit_o (at_limit)
  );

  // Next-state and fairness bookkeeping; CPU wins ties until the limit.
  always_comb begin
    state_d = state_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && (!dma_req || !at_limit)) begin
          state_d = ST_CPU_ACCESS;
          cnt_inc = dma_req;
        end else if (dma_req) begin
          state_d = ST_DMA_ACCESS;
          cnt_clr = 1'b1;
        end
      end
      ST_CPU_ACCESS:  if (Cpu_AS_L) state_d = ST_CPU_RELEASE;
      ST_CPU_RELEASE: state_d = ST_IDLE;
      ST_DMA_ACCESS:  if (!Dram_Dtack_L) state_d = ST_DMA_RELEASE;
      ST_DMA_RELEASE: state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // Owner bus mux; the DMA always moves a full word as a DRAM access.
  always_comb begin
    cpu_bus = '{address: Cpu_Address, data_in: Cpu_DataIn, uds_l: Cpu_UDS_L,
                lds_l: Cpu_LDS_L, we_l: Cpu_WE_L, as_l: Cpu_AS_L,
                dram_select_l: Cpu_DramSelect_L};
    dma_bus = '{address: Dma_Address, data_in: Dma_DataIn, uds_l: 1'b0,
                lds_l: 1'b0, we_l: Dma_WE_L, as_l: 1'b0, dram_select_l: 1'b0};
    bus         = parked_bus(hold_addr_q, hold_data_q);
    Cpu_Dtack_L = 1'b1;
    case (state_q)
      ST_CPU_ACCESS: begin
        bus         = cpu_bus;
        Cpu_Dtack_L = Dram_Dtack_L;
      end
      ST_DMA_ACCESS: bus = dma_bus;
      default: ;
    endcase
  end

  // State, held address/data of the last owner, and DMA read-back/ack.
  always_ff @(posedge Clock) begin
    if (!Reset_L) begin
      state_q     <= ST_IDLE;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      dma_data_q  <= '0;
      ack_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_CPU_ACCESS) || (state_q == ST_DMA_ACCESS)) begin
        hold_addr_q <= bus.address;
        hold_data_q <= bus.data_in;
      end
      if (dma_done) dma_data_q <= Dram_DataOut;
      ack_q <= dma_done;
    end
  end

  assign Dram_Address      = bus.address;
  assign Dram_DataIn       = bus.data_in;
  assign Dram_UDS_L        = bus.uds_l;
  assign Dram_LDS_L        = bus.lds_l;
  assign Dram_WE_L         = bus.we_l;
  assign Dram_AS_L         = bus.as_l;
  assign Dram_DramSelect_L = bus.dram_select_l;
  assign Dma_Ack_H         = ack_q;
  assign Dma_DataOut       = dma_data_q;
  assign ArbState          = state_q;

endmodule

// File: tb/tb_dram_bus_arbiter.sv
// Directed bench for dram_bus_arbiter: a per-cycle vector table for the
// basic CPU and DMA transactions, plus hand sequences for fairness,
// CPU wait-stating under DMA, DMA read-back and reset mid-access.
module tb_dram_bus_arbiter;

  logic        Clock = 1'b0;
  logic        Reset_L;
  logic [31:0] Cpu_Address;
  logic [15:0] Cpu_DataIn;
  logic        Cpu_UDS_L, Cpu_LDS_L, Cpu_WE_L, Cpu_AS_L, Cpu_DramSelect_L;
  logic        Cpu_Dtack_L;
  logic        Dma_Req_H;
  logic [31:0] Dma_Address;
  logic [15:0] Dma_DataIn;
  logic        Dma_WE_L;
  logic        Dma_Ack_H;
  logic [15:0] Dma_DataOut;
  logic [31:0] Dram_Address;
  logic [15:0] Dram_DataIn;
  logic        Dram_UDS_L, Dram_LDS_L, Dram_WE_L, Dram_AS_L, Dram_DramSelect_L;
  logic [15:0] Dram_DataOut;
  logic        Dram_Dtack_L;
  logic [2:0]  ArbState;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] CPU_A = 32'h00F0_0010;
  localparam logic [31:0] DMA_A = 32'h00F0_0100;

  dram_bus_arbiter dut (
    .Clock(Clock), .Reset_L(Reset_L),
    .Cpu_Address(Cpu_Address), .Cpu_DataIn(Cpu_DataIn),
    .Cpu_UDS_L(Cpu_UDS_L), .Cpu_LDS_L(Cpu_LDS_L), .Cpu_WE_L(Cpu_WE_L),
    .Cpu_AS_L(Cpu_AS_L), .Cpu_DramSelect_L(Cpu_DramSelect_L),
    .Cpu_Dtack_L(Cpu_Dtack_L),
    .Dma_Req_H(Dma_Req_H), .Dma_Address(Dma_Address), .Dma_DataIn(Dma_DataIn),
    .Dma_WE_L(Dma_WE_L), .Dma_Ack_H(Dma_Ack_H), .Dma_DataOut(Dma_DataOut),
    .Dram_Address(Dram_Address), .Dram_DataIn(Dram_DataIn),
    .Dram_UDS_L(Dram_UDS_L), .Dram_LDS_L(Dram_LDS_L), .Dram_WE_L(Dram_WE_L),
    .Dram_AS_L(Dram_AS_L), .Dram_DramSelect_L(Dram_DramSelect_L),
    .Dram_DataOut(Dram_DataOut), .Dram_Dtack_L(Dram_Dtack_L),
    .ArbState(ArbState)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        cpu_as_l, cpu_sel_l, dma_req, dtack_l;
    logic [2:0]  st;
    logic        das, cdt, ack, we, ds;
    logic [31:0] addr;
    logic [15:0] data;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(negedge Clock);
  endtask

  logic [2:0] exp_g;
  logic [2:0] grant;

  initial begin
    // cpu_as sel dma dtack | state das cdt ack we ds | addr data
    tbl[0]  = '{1'b1,1'b1,1'b0,1'b1, 3'd0,1'b1,1'b1,1'b0,1'b1,1'b1, 32'h0, 16'h0};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b1, 3'd0,1'b1,1'b1,1'b0,1'b1,1'b1, 32'h0, 16'h0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b1, 3'd0,1'b1,1'b1,1'b0,1'b1,1'b1, 32'h0, 16'h0};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b1, 3'd1,1'b0,1'b1,1'b0,1'b1,1'b0, CPU_A, 16'h5A5A};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b1, 3'd1,1'b0,1'b1,1'b0,1'b1,1'b0, CPU_A, 16'h5A5A};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0, 3'd1,1'b0,1'b0,1'b0,1'b1,1'b0, CPU_A, 16'h5A5A};
    tbl[6]  = '{1'b1,1'b1,1'b0,1'b1, 3'd1,1'b1,1'b1,1'b0,1'b1,1'b0, CPU_A, 16'h5A5A};
    tbl[7]  = '{1'b1,1'b1,1'b0,1'b1, 3'd2,1'b1,1'b1,1'b0,1'b1,1'b1, CPU_A, 16'h5A5A};
    tbl[8]  = '{1'b1,1'b1,1'b1,1'b1, 3'd0,1'b1,1'b1,1'b0,1'b1,1'b1, CPU_A, 16'h5A5A};
    tbl[9]  = '{1'b1,1'b1,1'b1,1'b1, 3'd3,1'b0,1'b1,1'b0,1'b0,1'b0, DMA_A, 16'hBEEF};
    tbl[10] = '{1'b1,1'b1,1'b1,1'b0, 3'd3,1'b0,1'b1,1'b0,1'b0,1'b0, DMA_A, 16'hBEEF};
    tbl[11] = '{1'b1,1'b1,1'b0,1'b1, 3'd4,1'b1,1'b1,1'b1,1'b1,1'b1, DMA_A, 16'hBEEF};
    tbl[12] = '{1'b1,1'b1,1'b0,1'b1, 3'd0,1'b1,1'b1,1'b0,1'b1,1'b1, DMA_A, 16'hBEEF};

    Reset_L = 1'b0;
    Cpu_Address = CPU_A; Cpu_DataIn = 16'h5A5A;
    Cpu_UDS_L = 1'b0; Cpu_LDS_L = 1'b0; Cpu_WE_L = 1'b1;
    Cpu_AS_L = 1'b1; Cpu_DramSelect_L = 1'b1;
    Dma_Req_H = 1'b0; Dma_Address = DMA_A; Dma_DataIn = 16'hBEEF; Dma_WE_L = 1'b0;
    Dram_DataOut = 16'h0000; Dram_Dtack_L = 1'b1;

    // Reset state
    repeat (3) next_cycle();
    #1;
    chk("rst_state", ArbState, 3'd0);
    chk("rst_dram_as", Dram_AS_L, 1'b1);
    chk("rst_dram_sel", Dram_DramSelect_L, 1'b1);
    chk("rst_cpu_dtack", Cpu_Dtack_L, 1'b1);
    chk("rst_ack", Dma_Ack_H, 1'b0);
    chk("rst_dma_data", Dma_DataOut, 16'h0);
    Reset_L = 1'b1;

    // CPU read then DMA write, one row per clock
    for (int i = 0; i < 13; i++) begin
      next_cycle();
      Cpu_AS_L = tbl[i].cpu_as_l; Cpu_DramSelect_L = tbl[i].cpu_sel_l;
      Dma_Req_H = tbl[i].dma_req; Dram_Dtack_L = tbl[i].dtack_l;
      #1;
      chk($sformatf("v%0d_state", i), ArbState, tbl[i].st);
      chk($sformatf("v%0d_dram_as", i), Dram_AS_L, tbl[i].das);
      chk($sformatf("v%0d_dram_sel", i), Dram_DramSelect_L, tbl[i].das);
      chk($sformatf("v%0d_cpu_dtack", i), Cpu_Dtack_L, tbl[i].cdt);
      chk($sformatf("v%0d_ack", i), Dma_Ack_H, tbl[i].ack);
      chk($sformatf("v%0d_we", i), Dram_WE_L, tbl[i].we);
      chk($sformatf("v%0d_uds", i), Dram_UDS_L, tbl[i].ds);
      chk($sformatf("v%0d_lds", i), Dram_LDS_L, tbl[i].ds);
      chk($sformatf("v%0d_addr", i), Dram_Address, tbl[i].addr);
      chk($sformatf("v%0d_data", i), Dram_DataIn, tbl[i].data);
    end

    // Both masters requesting continuously: C,C,C,C,D repeated
    for (int g = 0; g < 10; g++) begin
      next_cycle();
      Cpu_AS_L = 1'b0; Cpu_DramSelect_L = 1'b0; Dma_Req_H = 1'b1; Dram_Dtack_L = 1'b1;
      #1;
      chk($sformatf("rr%0d_idle", g), ArbState, 3'd0);
      next_cycle();
      #1;
      grant = ArbState;
      exp_g = ((g % 5) == 4) ? 3'd3 : 3'd1;
      chk($sformatf("rr%0d_grant", g), grant, exp_g);
      if (grant == 3'd3) begin
        Dram_Dtack_L = 1'b0;
        next_cycle();
        Dram_Dtack_L = 1'b1;
        #1;
        chk($sformatf("rr%0d_ack", g), Dma_Ack_H, 1'b1);
      end else begin
        Cpu_AS_L = 1'b1; Cpu_DramSelect_L = 1'b1;
        next_cycle();
        #1;
        chk($sformatf("rr%0d_release", g), ArbState, 3'd2);
      end
    end

    // CPU request arriving during DMA ownership is wait-stated
    next_cycle();
    Cpu_AS_L = 1'b1; Cpu_DramSelect_L = 1'b1; Dma_Req_H = 1'b1; Dram_Dtack_L = 1'b1;
    #1;
    chk("wd_idle", ArbState, 3'd0);
    next_cycle();
    Cpu_AS_L = 1'b0; Cpu_DramSelect_L = 1'b0;
    #1;
    chk("wd_dma_state", ArbState, 3'd3);
    chk("wd_cpu_dtack0", Cpu_Dtack_L, 1'b1);
    next_cycle();
    Dram_Dtack_L = 1'b0;
    #1;
    chk("wd_cpu_dtack1", Cpu_Dtack_L, 1'b1);
    next_cycle();
    Dram_Dtack_L = 1'b1; Dma_Req_H = 1'b0;
    #1;
    chk("wd_release", ArbState, 3'd4);
    chk("wd_release_ack", Dma_Ack_H, 1'b1);
    chk("wd_cpu_dtack2", Cpu_Dtack_L, 1'b1);
    next_cycle();
    #1;
    chk("wd_idle2", ArbState, 3'd0);
    next_cycle();
    #1;
    chk("wd_cpu_grant", ArbState, 3'd1);
    chk("wd_cpu_as", Dram_AS_L, 1'b0);
    Dram_Dtack_L = 1'b0;
    #1;
    chk("wd_cpu_dtack_pass", Cpu_Dtack_L, 1'b0);
    Cpu_AS_L = 1'b1; Cpu_DramSelect_L = 1'b1; Dram_Dtack_L = 1'b1;
    repeat (2) next_cycle();

    // DMA read returns the controller data and holds it after Ack
    next_cycle();
    Dma_Req_H = 1'b1; Dma_WE_L = 1'b1; Dram_DataOut = 16'h1234;
    #1;
    chk("rd_idle", ArbState, 3'd0);
    next_cycle();
    Dram_Dtack_L = 1'b0;
    #1;
    chk("rd_state", ArbState, 3'd3);
    chk("rd_we", Dram_WE_L, 1'b1);
    chk("rd_addr", Dram_Address, DMA_A);
    next_cycle();
    Dma_Req_H = 1'b0; Dram_Dtack_L = 1'b1; Dram_DataOut = 16'hFFFF;
    #1;
    chk("rd_ack", Dma_Ack_H, 1'b1);
    chk("rd_data", Dma_DataOut, 16'h1234);
    next_cycle();
    #1;
    chk("rd_ack_low", Dma_Ack_H, 1'b0);
    chk("rd_data_hold", Dma_DataOut, 16'h1234);
    chk("rd_back_idle", ArbState, 3'd0);

    // Reset asserted for one cycle in the middle of a CPU access
    Cpu_AS_L = 1'b0; Cpu_DramSelect_L = 1'b0;
    next_cycle();
    #1;
    chk("mr_cpu_state", ArbState, 3'd1);
    Reset_L = 1'b0; Dram_Dtack_L = 1'b0;
    next_cycle();
    #1;
    chk("mr_state", ArbState, 3'd0);
    chk("mr_dram_as", Dram_AS_L, 1'b1);
    chk("mr_dram_uds", Dram_UDS_L, 1'b1);
    chk("mr_dram_we", Dram_WE_L, 1'b1);
    chk("mr_dram_sel", Dram_DramSelect_L, 1'b1);
    chk("mr_cpu_dtack", Cpu_Dtack_L, 1'b1);
    chk("mr_dma_data", Dma_DataOut, 16'h0);
    Reset_L = 1'b1; Cpu_AS_L = 1'b1; Cpu_DramSelect_L = 1'b1; Dram_Dtack_L = 1'b1;
    next_cycle();
    #1;
    chk("mr_after", ArbState, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
